kf_seq: RTL

- Microcoded sequencer that initiates all traffic into the memory-register block (data bank plus RQ/RD accumulators).
- Steps through a small writable instruction store and drives the bank read addresses, the bank write strobe, the RQ/RD write enables and the ALU op.
- Handshakes with the ALU for multi-cycle operations.
- Sits between the top-level start/done control and mem_reg / Router A / Router B.

---
 rtl/kf_seq_if.sv | 31 +++
 rtl/kf_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/kf_seq_if.sv
// kf_seq_if: sequencer <-> ALU / memory-register bus.
//   alu_op    [3:0]    opcode presented to the ALU
//   alu_start          one-cycle ALU launch
//   alu_done           ALU result valid (driven by the ALU side)
//   write              data-bank write strobe
//   dira [ADDRW-1:0]   bank port A address (read and write)
//   dirb [ADDRW-1:0]   bank port B address
//   rq_we / rd_we      RQ / RD accumulator write enables
// master = sequencer, slave = ALU / mem_reg side.
interface kf_seq_if #(
  parameter int ADDRW = 5
);
  logic [3:0]       alu_op;
  logic             alu_start;
  logic             alu_done;
  logic             write;
  logic [ADDRW-1:0] dira;
  logic [ADDRW-1:0] dirb;
  logic             rq_we;
  logic             rd_we;

  modport master (
    output alu_op, alu_start, write, dira, dirb, rq_we, rd_we,
    input  alu_done
  );

  modport slave (
    input  alu_op, alu_start, write, dira, dirb, rq_we, rd_we,
    output alu_done
  );
endinterface

// File: rtl/kf_seq.sv
// kf_seq: microcoded sequencer driving the memory-register block and ALU.
// Steps through a writable instruction store (2**PCW words of IW bits),
// launches ALU ops, waits for alu_done with a timeout, and issues the
// bank / RQ / RD write strobes.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   prog_we/addr/data     instruction store write (only accepted in IDLE)
//   start                 one-cycle pulse, run program from pc 0
//   busy, done, err       run status; err sticky until next accepted start
//   bus (kf_seq_if.master) ALU handshake and bank control
// Instruction word: {op[3:0], a[ADDRW-1:0], b[ADDRW-1:0], wr, q, d, last}
// Optional feature: define KF_SEQ_LOOP_EN to give opcode 6 (LOOP) counted
// jump semantics; otherwise LOOP is a NOP and no counter exists.
//
// state | meaning
// IDLE  | waiting for start, store writable
// FETCH | ir <= store[pc]
// ISSUE | present a/b/op, launch ALU or dispatch MOV/NOP/LOOP
// WAIT  | hold bus, wait for alu_done or timeout
// WB    | one-cycle write strobes (write/rq_we/rd_we)
// DONE  | done pulse, back to IDLE
module kf_seq #(
  parameter int ADDRW = 5,
  parameter int PCW   = 6,
  parameter int TMO   = 63
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [PCW-1:0]         prog_addr,
  input  logic [8+2*ADDRW-1:0]   prog_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  kf_seq_if.master               bus
);
  localparam int IW = 8 + 2*ADDRW;
  localparam int NI = 2**PCW;
  localparam int TW = $clog2(TMO + 1);

  localparam logic [PCW-1:0] PC_ONE  = PCW'(1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(NI - 1);
  localparam logic [TW-1:0]  TMO_LD  = TW'(TMO - 1);
  localparam logic [TW-1:0]  TMO_ONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [PCW-1:0]   pc, pc_nxt;
  logic [IW-1:0]    ir, ir_nxt;
  logic             err_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_nxt;
  logic             adv;
  logic [IW-1:0]    mem [NI];

  logic [3:0]       ir_op;
  logic [ADDRW-1:0] ir_a, ir_b;
  logic             ir_wr, ir_q, ir_d, ir_last;

  assign ir_op   = ir[IW-1:IW-4];
  assign ir_a    = ir[IW-5:IW-4-ADDRW];
  assign ir_b    = ir[IW-5-ADDRW:4];
  assign ir_wr   = ir[3];
  assign ir_q    = ir[2];
  assign ir_d    = ir[1];
  assign ir_last = ir[0];

`ifdef KF_SEQ_LOOP_EN
  localparam logic [ADDRW-1:0] A_ONE = ADDRW'(1);
  logic [ADDRW-1:0] cnt, cnt_nxt;
  logic             loop_act, loop_act_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      loop_act <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      loop_act <= loop_act_nxt;
    end
  end
`endif

  // Instruction store has no reset.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      err     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      err     <= err_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    err_nxt       = err;
    tmo_nxt       = tmo_cnt;
    adv           = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    bus.alu_op    = '0;
    bus.alu_start = 1'b0;
    bus.write     = 1'b0;
    bus.dira      = '0;
    bus.dirb      = '0;
    bus.rq_we     = 1'b0;
    bus.rd_we     = 1'b0;
`ifdef KF_SEQ_LOOP_EN
    cnt_nxt       = cnt;
    loop_act_nxt  = loop_act;
`endif

    // a/b/op stay on the bus from ISSUE through WB so the bank write
    // address in WB is still a.
    if (state == S_ISSUE || state == S_WAIT || state == S_WB) begin
      bus.dira   = ir_a;
      bus.dirb   = ir_b;
      bus.alu_op = ir_op;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
          err_nxt   = 1'b0;
`ifdef KF_SEQ_LOOP_EN
          cnt_nxt      = '0;
          loop_act_nxt = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        ir_nxt    = mem[pc];
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        case (ir_op)
          4'd1, 4'd2, 4'd3, 4'd4: begin
            bus.alu_start = 1'b1;
            tmo_nxt       = TMO_LD;
            state_nxt     = S_WAIT;
          end
          4'd5: state_nxt = S_WB;
`ifdef KF_SEQ_LOOP_EN
          // loop_act distinguishes the first pass (load count) from later
          // passes (decrement) with the single shared counter.
          4'd6: begin
            if (!loop_act) begin
              if (ir_b == '0) begin
                adv = 1'b1;
              end else begin
                cnt_nxt      = ir_b - A_ONE;
                loop_act_nxt = 1'b1;
                pc_nxt       = PCW'(ir_a);
                state_nxt    = S_FETCH;
              end
            end else if (cnt != '0) begin
              cnt_nxt   = cnt - A_ONE;
              pc_nxt    = PCW'(ir_a);
              state_nxt = S_FETCH;
            end else begin
              loop_act_nxt = 1'b0;
              adv          = 1'b1;
            end
          end
`endif
          default: adv = 1'b1;
        endcase
      end
      S_WAIT: begin
        busy = 1'b1;
        if (bus.alu_done) begin
          state_nxt = S_WB;
        end else if (tmo_cnt == '0) begin
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          tmo_nxt = tmo_cnt - TMO_ONE;
        end
      end
      S_WB: begin
        busy      = 1'b1;
        bus.write = ir_wr;
        bus.rq_we = ir_q;
        bus.rd_we = ir_d;
        adv       = 1'b1;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Next-instruction logic; the pc never wraps past the last word.
    if (adv) begin
      if (ir_last) begin
        state_nxt = S_DONE;
      end else if (pc == PC_LAST) begin
        err_nxt   = 1'b1;
        state_nxt = S_DONE;
      end else begin
        pc_nxt    = pc + PC_ONE;
        state_nxt = S_FETCH;
      end
    end
  end
endmodule
